// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - pattern write / commit port of the seven-segment scan controller
interface seg7_scan_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit,
        input  commit_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output commit_ack
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - double-buffered 8-digit seven-segment refresh scheduler
module seg7_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYC     = 2000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        blink_mask,
    seg7_scan_ctrl_if.slave   host,
    output logic              frame_done,
    output logic [7:0]        seg0,
    output logic [7:0]        seg1,
    output logic [7:0]        dig_sel
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [7:0]    shadow [8];
    logic [7:0]    active [8];
    logic [DW-1:0] div_cnt;
    logic [1:0]    slot;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          pending;

    logic          div_last;
    logic          fe;
    logic          do_copy;
    logic          lit;
    logic [7:0]    nxt_dig;
    logic [7:0]    nxt_seg0;
    logic [7:0]    nxt_seg1;

    assign div_last = (div_cnt == DW'(SCAN_DIV - 1));
    assign fe       = en && div_last && (slot == 2'd3);
    assign do_copy  = fe && (pending || host.commit);
    assign lit      = en && (div_cnt >= DW'(DEAD_CYC));

    // Both groups share the slot index; digit slot+4 drives the DN1 bus.
    always_comb begin
        nxt_dig  = 8'h00;
        nxt_seg0 = 8'h00;
        nxt_seg1 = 8'h00;
        if (lit) begin
            nxt_dig[{1'b0, slot}] = 1'b1;
            nxt_dig[{1'b1, slot}] = 1'b1;
            if (!(blink_mask[{1'b0, slot}] && blink_phase))
                nxt_seg0 = active[{1'b0, slot}];
            if (!(blink_mask[{1'b1, slot}] && blink_phase))
                nxt_seg1 = active[{1'b1, slot}];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
            div_cnt         <= '0;
            slot            <= 2'd0;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            pending         <= 1'b0;
            frame_done      <= 1'b0;
            host.commit_ack <= 1'b0;
            seg0            <= 8'h00;
            seg1            <= 8'h00;
            dig_sel         <= 8'h00;
        end else begin
            if (host.wr_en)
                shadow[host.wr_addr] <= host.wr_data;

            if (!en) begin
                div_cnt <= '0;
                slot    <= 2'd0;
            end else if (div_last) begin
                div_cnt <= '0;
                slot    <= slot + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fe) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // The copy reads shadow before this edge, so a same-edge write waits for the next commit.
            if (do_copy) begin
                for (int i = 0; i < 8; i++)
                    active[i] <= shadow[i];
                pending <= 1'b0;
            end else if (host.commit) begin
                pending <= 1'b1;
            end

            frame_done      <= fe;
            host.commit_ack <= do_copy;
            dig_sel         <= nxt_dig;
            seg0            <= nxt_seg0;
            seg1            <= nxt_seg1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] blink_mask;
    logic       frame_done;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] dig_sel;

    seg7_scan_ctrl_if hif ();

    seg7_scan_ctrl #(
        .SCAN_DIV     (8),
        .DEAD_CYC     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .blink_mask (blink_mask),
        .host       (hif),
        .frame_done (frame_done),
        .seg0       (seg0),
        .seg1       (seg1),
        .dig_sel    (dig_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [7:0] dig;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       fd;
        logic       ack;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] e_act [8];
    logic [7:0] e_blank;
    int         t0, t1, t2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int tag, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %02h expected %02h", name, tag, act, exp);
        end
    endtask

    // Expected frame f relative to an enable point: slots of 8 cycles, 2 dark, frame end pulse on the 32nd sample.
    task automatic push_frame(int base, int f, bit ack_end, int nmax);
        for (int n = 32 * f + 1; n <= 32 * f + 32 && n <= nmax; n++) begin
            int   k = n - 1;
            int   s = (k / 8) % 4;
            exp_t e;
            e.tag = base + n;
            e.dig = 8'h00;
            e.s0  = 8'h00;
            e.s1  = 8'h00;
            if ((k % 8) >= 2) begin
                e.dig = 8'(1 << s) | 8'(1 << (s + 4));
                e.s0  = e_blank[s]     ? 8'h00 : e_act[s];
                e.s1  = e_blank[s + 4] ? 8'h00 : e_act[s + 4];
            end
            e.fd  = (n % 32) == 0;
            e.ack = e.fd && ack_end;
            q.push_back(e);
        end
    endtask

    task automatic push_zero(int tag);
        exp_t e;
        e.tag = tag; e.dig = 8'h00; e.s0 = 8'h00; e.s1 = 8'h00; e.fd = 1'b0; e.ack = 1'b0;
        q.push_back(e);
    endtask

    task automatic check_dark(string name);
        check({name, "_dig"}, cyc, dig_sel, 8'h00);
        check({name, "_seg0"}, cyc, seg0, 8'h00);
        check({name, "_seg1"}, cyc, seg1, 8'h00);
        check({name, "_fd"}, cyc, {7'd0, frame_done}, 8'h00);
        check({name, "_ack"}, cyc, {7'd0, hif.commit_ack}, 8'h00);
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic host_write(logic [2:0] a, logic [7:0] d);
        hif.wr_en = 1'b1; hif.wr_addr = a; hif.wr_data = d;
        @(negedge clk);
        hif.wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        hif.commit = 1'b1;
        @(negedge clk);
        hif.commit = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) e_act[i] = 8'h00;
        e_blank = 8'h00;
    endtask

    // Monitor: pops every expectation due at this sample point.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tag <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.tag < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_sample tag %0d at cyc %0d", e.tag, cyc);
                end else begin
                    check("dig_sel", e.tag, dig_sel, e.dig);
                    check("seg0", e.tag, seg0, e.s0);
                    check("seg1", e.tag, seg1, e.s1);
                    check("frame_done", e.tag, {7'd0, frame_done}, {7'd0, e.fd});
                    check("commit_ack", e.tag, {7'd0, hif.commit_ack}, {7'd0, e.ack});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; blink_mask = 8'h00;
        hif.wr_en = 1'b0; hif.wr_addr = 3'd0; hif.wr_data = 8'h00; hif.commit = 1'b0;
        clear_exp();
        repeat (3) @(negedge clk);
        check_dark("reset");
        rst = 1'b0;
        en  = 1'b1;
        t0  = cyc;

        // Blank scan, then first commit of 0x06 / 0x5B, then an FE-coincident write+commit.
        push_frame(t0, 0, 1'b0, 9999);
        push_frame(t0, 1, 1'b1, 9999);
        e_act[0] = 8'h06; e_act[5] = 8'h5B;
        push_frame(t0, 2, 1'b1, 9999);
        push_frame(t0, 3, 1'b1, 9999);
        e_act[0] = 8'h4F;
        push_frame(t0, 4, 1'b0, 9999);
        push_frame(t0, 5, 1'b1, 9999);
        e_act[0] = 8'h77; e_blank = 8'h01;
        push_frame(t0, 6, 1'b0, 9999);
        push_frame(t0, 7, 1'b0, 9999);
        e_blank = 8'h00;
        push_frame(t0, 8, 1'b0, 9999);
        push_frame(t0, 9, 1'b0, 9999);
        e_blank = 8'h01;
        push_frame(t0, 10, 1'b0, 339);
        for (int c = 340; c <= 346; c++) push_zero(t0 + c);

        wait_to(t0 + 40);
        host_write(3'd0, 8'h06);
        host_write(3'd5, 8'h5B);
        pulse_commit();

        wait_to(t0 + 95);
        hif.wr_en = 1'b1; hif.wr_addr = 3'd0; hif.wr_data = 8'h4F; hif.commit = 1'b1;
        @(negedge clk);
        hif.wr_en = 1'b0; hif.commit = 1'b0;

        // Two commits in one frame merge into a single copy.
        wait_to(t0 + 100);
        pulse_commit();
        wait_to(t0 + 110);
        pulse_commit();

        wait_to(t0 + 128);
        blink_mask = 8'h01;
        wait_to(t0 + 130);
        host_write(3'd0, 8'h77);
        wait_to(t0 + 170);
        pulse_commit();

        // Disable mid slot 2, write and commit while dark, then re-enable.
        wait_to(t0 + 339);
        en = 1'b0;
        wait_to(t0 + 341);
        host_write(3'd0, 8'h39);
        pulse_commit();
        blink_mask = 8'h00;
        wait_to(t0 + 346);
        en = 1'b1;
        t1 = cyc;
        e_act[0] = 8'h77; e_blank = 8'h00;
        push_frame(t1, 0, 1'b1, 9999);
        e_act[0] = 8'h39;
        push_frame(t1, 1, 1'b0, 9999);
        push_frame(t1, 2, 1'b0, 76);

        // Reset with a commit pending drops the commit and clears both buffers.
        wait_to(t1 + 69);
        pulse_commit();
        wait_to(t1 + 76);
        #2;
        rst = 1'b1;
        #1;
        check_dark("async_rst");
        @(negedge clk);
        rst = 1'b0;
        t2  = cyc;
        clear_exp();
        push_frame(t2, 0, 1'b0, 9999);
        push_frame(t2, 1, 1'b0, 9999);
        push_frame(t2, 2, 1'b0, 9999);
        wait_to(t2 + 96);
        repeat (2) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed refresh scheduler for the board's 8-digit seven-segment display: two segment buses (seg0 for DN0 group, seg1 for DN1 group), four chip-selects per group.
- Holds a double-buffered 8-entry pattern memory. Upstream mode/menu logic writes raw segment patterns into a shadow buffer.
- Shadow-to-active copy happens only at frame boundaries, so partial updates never show.
- Scans both groups in parallel with per-slot dead time and per-digit blink.

Parameters:
SCAN_DIV, 100000, clock cycles per scan slot (1 kHz slot rate at 100 MHz); minimum 4.
DEAD_CYC, 2000, cycles at the start of each slot with all selects off (anti-ghosting); must be < SCAN_DIV.
BLINK_FRAMES, 125, full frames per blink half-period; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  scan enable; 0 = display dark, scan counters held at 0
wr_en  in  1  write strobe to shadow buffer
wr_addr  in  3  digit index: 0-3 = DN0 K1..K4, 4-7 = DN1 K1..K4
wr_data  in  8  segment pattern {DP,G,F,E,D,C,B,A}, active-high
commit  in  1  single-cycle request to copy shadow to active at next frame end
blink_mask  in  8  per-digit blink enable, bit i = digit i
commit_ack  out  1  one-cycle pulse when the copy is performed
frame_done  out  1  one-cycle pulse after each completed 4-slot frame
seg0  out  8  DN0 group segments, active-high, registered
seg1  out  8  DN1 group segments, active-high, registered
dig_sel  out  8  {DN1_K4..K1, DN0_K4..K1}, active-high, registered

Behaviour:
Reset (asynchronous, rst=1):
- seg0, seg1, dig_sel, commit_ack, frame_done = 0.
- Shadow and active buffers all 0. div_cnt=0, slot=0, frame_cnt=0, blink_phase=0, pending=0.

Counters (en=1):
- div_cnt counts 0..SCAN_DIV-1 and wraps.
- At div_cnt=SCAN_DIV-1, slot increments with wrap 3->0.
- Frame end (FE) = slot==3 && div_cnt==SCAN_DIV-1.
- frame_done is asserted in the cycle after FE.

Blink:
- frame_cnt counts FEs from 0..BLINK_FRAMES-1.
- On the FE where frame_cnt==BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_phase toggles.

Outputs (registered, 1-cycle latency from counter state):
- If div_cnt < DEAD_CYC: dig_sel=0, seg0=0, seg1=0.
- Otherwise:
  - dig_sel = (1<<slot) | (1<<(slot+4)).
  - seg0 = active[slot], or 0 if blink_mask[slot] && blink_phase.
  - seg1 = active[slot+4], or 0 if blink_mask[slot+4] && blink_phase.
- Blink blanks the segments only; dig_sel timing is unchanged.

Writes:
- wr_en writes shadow[wr_addr] <= wr_data at the clock edge, any time, including when en=0.
- The active buffer is never written directly.

Commit:
- commit=1 sets pending.
- At an FE edge where (pending || commit), active <= shadow as it was before that edge. A write on the same cycle as FE lands in shadow only.
- The same edge clears pending. commit_ack pulses in the following cycle, coincident with frame_done.
- commit asserted while pending=1 merges into the same copy: one ack only.

Disable (en=0):
- Next edge: div_cnt=0, slot=0, outputs 0.
- frame_cnt, blink_phase, pending and both buffers are retained.
- No FE occurs, so no commit and no pulses.
- On re-enable, scanning restarts at slot 0 with a dead period.

Mid-operation reset:
- Immediate asynchronous clear of everything listed under Reset, including a pending commit.

Test Plan:
(Parameters for all scenarios: SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.)
1. Reset then en=1, no writes:
   - dig_sel cycles 0x00,0x00 then 0x11 for 6 cycles, 0x00×2, then 0x22, 0x44, 0x88.
   - seg0=seg1=0 throughout.
   - frame_done pulses every 32 cycles.
2. Write 0x06 to addr 0 and 0x5B to addr 5, then commit:
   - Active buffer unchanged until FE; commit_ack coincides with the next frame_done.
   - Afterwards, seg0=0x06 during the 0x11 select phase and seg1=0x5B during the 0x22 phase.
3. Write addr 0 = 0x4F on the exact FE cycle together with commit:
   - Displayed digit 0 keeps its old value.
   - Pending is then clear, so the new value appears only after a second commit.
4. blink_mask=0x01 with active[0]=0x77:
   - seg0=0x77 in slot 0 for frames 0-1, 0 for frames 2-3, 0x77 again in frames 4-5.
   - dig_sel is identical in all frames.
5. Drop en mid-slot 2:
   - Next cycle all outputs are 0.
   - Re-enable: dig_sel=0 for 2 cycles, then 0x11.
   - A commit issued while disabled is acked at the first FE after re-enable.
6. Assert rst during pending commit mid-frame:
   - Outputs are immediately 0.
   - After release, no commit_ack ever occurs without a new commit, and the active buffer reads 0.
